char_stream_normalizer: RTL and testbench
=========================================

Name: char_stream_normalizer

Overview:
- Upstream stage of the keyword block checker. Accepts a raw byte stream from the input source through a valid/ready handshake.
- Produces a cleaned ASCII character stream for the checker:
  - upper case folded to lower case;
  - tab/LF/CR mapped to space;
  - separator runs collapsed to one space;
  - control bytes dropped.
- A guaranteed space is inserted before every end-of-stream NUL, so the final word is always terminated.
- An internal FIFO decouples the producer from the consumer.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 4
AW, 3, pointer width = log2(DEPTH)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
in_char  input  8  raw byte from producer
in_valid  input  1  in_char valid this cycle
in_ready  output  1  block can accept in_char this cycle
out_char  output  8  normalized character, FIFO head
out_valid  output  1  out_char valid
out_ready  input  1  consumer takes out_char this cycle
fifo_level  output  AW+1  current FIFO occupancy, 0..DEPTH
drop_count  output  16  number of dropped bytes, saturating

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - rd/wr pointers 0, fifo_level 0, out_valid 0, out_char 0x00;
  - in_ready 1, drop_count 0;
  - prev_sep 1 (so leading separators are suppressed), state NORM.
- Reset asserted mid-stream discards FIFO contents and any pending pad on the same edge.
- Accept: occurs when in_valid && in_ready; the byte is classified in the same cycle.
  - 0x41-0x5A: write in_char+0x20; prev_sep<=0.
  - 0x21-0x7E (other): write unchanged; prev_sep<=0.
  - 0x20, 0x09, 0x0A, 0x0D: if prev_sep=0, write 0x20 and set prev_sep<=1; otherwise no write.
  - 0x00 (EOS), prev_sep=1: write 0x00; stay NORM; prev_sep stays 1.
  - 0x00 (EOS), prev_sep=0: write 0x20; state<=EOS_PAD.
  - 0x01-0x08, 0x0B, 0x0C, 0x0E-0x1F, 0x7F-0xFF: no write; drop_count+1, saturating at 0xFFFF.
- FSM:
  - NORM: in_ready = !full.
  - EOS_PAD: in_ready=0. When !full, write 0x00, set prev_sep<=1, return to NORM. If full, remain in EOS_PAD.
- FIFO (first-word-fall-through):
  - out_valid = (fifo_level != 0).
  - out_char = mem[rd_ptr] when valid, 0x00 when empty.
  - Pop on out_valid && out_ready.
  - Latency: a byte accepted into an empty FIFO appears on out_char/out_valid the next cycle.
- Full/empty boundaries:
  - full = (fifo_level == DEPTH). in_ready is computed from full only, so there is no push into a full FIFO even if a pop occurs the same cycle.
  - Pop while empty is ignored.
  - Simultaneous push and pop: fifo_level unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
- Order preservation: output order equals accepted-byte order. At most one write per cycle.
- Consumer stalls: out_char and out_valid hold stable while out_ready=0.

Test Plan:
- Case folding and collapse: feed "BeGiN\t\t END" then 0x00, out_ready=1 -> output "begin end " followed by 0x00. Total of 11 bytes; out_valid first high 1 cycle after the first accept.
- Leading separators: feed "  \r\nx " then 0x00 -> output "x " then 0x00. drop_count=0.
- Drops: feed 0x01, 0x7F, 0xC3, 'a', 0x1B, then 0x00 -> output 'a', 0x20, 0x00. drop_count=4.
- Full/backpressure with DEPTH=8 and out_ready=0:
  - Feed 9 letters -> in_ready goes low after 8 accepts, fifo_level=8, 9th byte held by producer.
  - Raise out_ready for one cycle -> level 7; next cycle the 9th byte is accepted.
- EOS pad blocked by full: fill 7 entries with letters, then send 0x00.
  - Pad 0x20 is written (level 8); state EOS_PAD with in_ready=0.
  - After one pop, 0x00 is written and in_ready returns to 1 the following cycle.
- Reset mid-operation: with level=5 and state EOS_PAD, pulse reset one cycle.
  - Next cycle: out_valid=0, fifo_level=0, in_ready=1, drop_count=0.
  - Subsequent " a" yields only 'a'.

Source files
------------

// File: rtl/char_stream_normalizer.sv
// Byte-stream normalizer ahead of the keyword checker: folds case, collapses separator runs,
// drops control bytes, pads a space before end-of-stream NUL, buffers through a FWFT FIFO.
module char_stream_normalizer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    in_char,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [7:0]    out_char,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW:0]   fifo_level,
    output logic [15:0]   drop_count
);

    typedef enum logic [0:0] {StNorm, StEosPad} state_e;

    localparam logic [AW:0] FullLevel = (AW + 1)'(DEPTH);

    state_e          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     level_q, level_d;
    logic            prev_sep_q, prev_sep_d;
    logic [15:0]     drop_q, drop_d;
    logic [7:0]      mem_q [DEPTH];

    logic            full;
    logic            accept;
    logic            pop;
    logic            push;
    logic [7:0]      wdata;
    logic            is_upper;
    logic            is_print;
    logic            is_sep;
    logic            is_eos;

    // in_ready looks only at full, so a same-cycle pop never makes room for a push.
    assign full       = (level_q == FullLevel);
    assign in_ready   = (state_q == StNorm) && !full;
    assign accept     = in_valid && in_ready;
    assign out_valid  = (level_q != '0);
    assign pop        = out_valid && out_ready;
    assign out_char   = out_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign fifo_level = level_q;
    assign drop_count = drop_q;

    assign is_upper = (in_char >= 8'h41) && (in_char <= 8'h5A);
    assign is_print = (in_char >= 8'h21) && (in_char <= 8'h7E);
    assign is_sep   = (in_char == 8'h20) || (in_char == 8'h09) ||
                      (in_char == 8'h0A) || (in_char == 8'h0D);
    assign is_eos   = (in_char == 8'h00);

    always_comb begin
        push       = 1'b0;
        wdata      = 8'h00;
        state_d    = state_q;
        prev_sep_d = prev_sep_q;
        drop_d     = drop_q;
        case (state_q)
            StNorm: begin
                if (accept) begin
                    if (is_upper) begin
                        push       = 1'b1;
                        wdata      = in_char + 8'h20;
                        prev_sep_d = 1'b0;
                    end else if (is_print) begin
                        push       = 1'b1;
                        wdata      = in_char;
                        prev_sep_d = 1'b0;
                    end else if (is_sep) begin
                        if (!prev_sep_q) begin
                            push       = 1'b1;
                            wdata      = 8'h20;
                            prev_sep_d = 1'b1;
                        end
                    end else if (is_eos) begin
                        push = 1'b1;
                        // An unterminated word gets a space first; the NUL follows from StEosPad.
                        if (prev_sep_q) begin
                            wdata = 8'h00;
                        end else begin
                            wdata   = 8'h20;
                            state_d = StEosPad;
                        end
                    end else if (drop_q != 16'hFFFF) begin
                        drop_d = drop_q + 16'd1;
                    end
                end
            end
            StEosPad: begin
                if (!full) begin
                    push       = 1'b1;
                    wdata      = 8'h00;
                    prev_sep_d = 1'b1;
                    state_d    = StNorm;
                end
            end
            default: state_d = StNorm;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q + (AW + 1)'(push) - (AW + 1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StNorm;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            prev_sep_q <= 1'b1;
            drop_q     <= 16'h0000;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            prev_sep_q <= prev_sep_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: tb/tb_char_stream_normalizer.sv
// Directed bench for char_stream_normalizer: one task per scenario, inline expected values.
module tb_char_stream_normalizer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_char;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_char;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  fifo_level;
    logic [15:0] drop_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] stim_q [$];
    logic [7:0] exp_q  [$];
    logic [7:0] got_q  [$];

    char_stream_normalizer #(
        .DEPTH (8),
        .AW    (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_char    (in_char),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_char   (out_char),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_level (fifo_level),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push_byte(input logic [7:0] b);
        int n = 0;
        in_char  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL push_timeout: in_ready got 0 required 1 for byte %02h", b);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic feed();
        foreach (stim_q[i]) push_byte(stim_q[i]);
    endtask

    task automatic collect(input int n);
        int cyc = 0;
        got_q.delete();
        while (got_q.size() < n && cyc < 300) begin
            if (out_valid && out_ready) got_q.push_back(out_char);
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid);
        end
        checks++;
        if (out_char !== 8'h00) begin
            errors++; $display("FAIL reset_out_char: got %02h required 00", out_char);
        end
        checks++;
        if (fifo_level !== 4'd0) begin
            errors++; $display("FAIL reset_level: got %0d required 0", fifo_level);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
        checks++;
        if (drop_count !== 16'd0) begin
            errors++; $display("FAIL reset_drop: got %0d required 0", drop_count);
        end
    endtask

    task automatic test_latency();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL lat_pre_valid: got %b required 0", out_valid);
        end
        push_byte(8'h51);
        checks++;
        if (out_valid !== 1'b1 || out_char !== 8'h71) begin
            errors++;
            $display("FAIL lat_first: got valid=%b char=%02h required valid=1 char=71",
                     out_valid, out_char);
        end
        push_byte(8'h00);
        exp_q = '{8'h71, 8'h20, 8'h00};
        out_ready = 1'b1;
        collect(3);
        out_ready = 1'b0;
        foreach (exp_q[i]) begin
            checks++;
            if (got_q.size() <= i || got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL lat_stream[%0d]: got %02h required %02h",
                                   i, (got_q.size() > i) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_fold_collapse();
        stim_q = '{"B", "e", "G", "i", "N", 8'h09, 8'h09, " ", "E", "N", "D", 8'h00};
        exp_q  = '{"b", "e", "g", "i", "n", " ", "e", "n", "d", " ", 8'h00};
        out_ready = 1'b1;
        fork
            feed();
            collect(11);
        join
        out_ready = 1'b0;
        checks++;
        if (got_q.size() != 11) begin
            errors++; $display("FAIL fold_count: got %0d required 11", got_q.size());
        end
        foreach (exp_q[i]) begin
            checks++;
            if (got_q.size() <= i || got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL fold[%0d]: got %02h required %02h",
                                   i, (got_q.size() > i) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
        checks++;
        if (fifo_level !== 4'd0) begin
            errors++; $display("FAIL fold_level: got %0d required 0", fifo_level);
        end
    endtask

    task automatic test_leading_sep();
        stim_q = '{8'h20, 8'h20, 8'h0D, 8'h0A, "x", 8'h20, 8'h00};
        exp_q  = '{"x", 8'h20, 8'h00};
        out_ready = 1'b1;
        fork
            feed();
            collect(3);
        join
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        foreach (exp_q[i]) begin
            checks++;
            if (got_q.size() <= i || got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL lead[%0d]: got %02h required %02h",
                                   i, (got_q.size() > i) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
        checks++;
        if (fifo_level !== 4'd0) begin
            errors++; $display("FAIL lead_extra: level got %0d required 0", fifo_level);
        end
        checks++;
        if (drop_count !== 16'd0) begin
            errors++; $display("FAIL lead_drop: got %0d required 0", drop_count);
        end
    endtask

    task automatic test_drops();
        stim_q = '{8'h01, 8'h7F, 8'hC3, "a", 8'h1B, 8'h00};
        exp_q  = '{"a", 8'h20, 8'h00};
        out_ready = 1'b1;
        fork
            feed();
            collect(3);
        join
        out_ready = 1'b0;
        foreach (exp_q[i]) begin
            checks++;
            if (got_q.size() <= i || got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL drop[%0d]: got %02h required %02h",
                                   i, (got_q.size() > i) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
        checks++;
        if (drop_count !== 16'd4) begin
            errors++; $display("FAIL drop_count: got %0d required 4", drop_count);
        end
    endtask

    task automatic test_full_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_byte(8'h41 + 8'(i));
        checks++;
        if (fifo_level !== 4'd8 || in_ready !== 1'b0) begin
            errors++; $display("FAIL full_level: got level=%0d ready=%b required 8/0",
                               fifo_level, in_ready);
        end
        in_char  = 8'h49;
        in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (fifo_level !== 4'd8 || in_ready !== 1'b0 || out_char !== 8'h61) begin
            errors++; $display("FAIL full_hold: got level=%0d ready=%b char=%02h required 8/0/61",
                               fifo_level, in_ready, out_char);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (fifo_level !== 4'd7 || in_ready !== 1'b1) begin
            errors++; $display("FAIL full_pop: got level=%0d ready=%b required 7/1",
                               fifo_level, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (fifo_level !== 4'd8) begin
            errors++; $display("FAIL full_ninth: level got %0d required 8", fifo_level);
        end
        exp_q = '{"b", "c", "d", "e", "f", "g", "h", "i"};
        out_ready = 1'b1;
        collect(8);
        out_ready = 1'b0;
        foreach (exp_q[i]) begin
            checks++;
            if (got_q.size() <= i || got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL full_order[%0d]: got %02h required %02h",
                                   i, (got_q.size() > i) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_eos_pad_full();
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) push_byte(8'h6A + 8'(i));
        push_byte(8'h00);
        checks++;
        if (fifo_level !== 4'd8 || in_ready !== 1'b0) begin
            errors++; $display("FAIL pad_written: got level=%0d ready=%b required 8/0",
                               fifo_level, in_ready);
        end
        @(negedge clk);
        checks++;
        if (fifo_level !== 4'd8 || in_ready !== 1'b0) begin
            errors++; $display("FAIL pad_blocked: got level=%0d ready=%b required 8/0",
                               fifo_level, in_ready);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (fifo_level !== 4'd7 || in_ready !== 1'b0) begin
            errors++; $display("FAIL pad_after_pop: got level=%0d ready=%b required 7/0",
                               fifo_level, in_ready);
        end
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (fifo_level !== 4'd7 || in_ready !== 1'b1) begin
            errors++; $display("FAIL pad_nul: got level=%0d ready=%b required 7/1",
                               fifo_level, in_ready);
        end
        exp_q = '{"l", "m", "n", "o", "p", 8'h20, 8'h00};
        out_ready = 1'b1;
        collect(7);
        out_ready = 1'b0;
        foreach (exp_q[i]) begin
            checks++;
            if (got_q.size() <= i || got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL pad_order[%0d]: got %02h required %02h",
                                   i, (got_q.size() > i) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        stim_q = '{8'h05, "w", "x", "y", "z", 8'h00};
        feed();
        checks++;
        if (fifo_level !== 4'd5 || in_ready !== 1'b0 || drop_count !== 16'd5) begin
            errors++; $display("FAIL mid_setup: got level=%0d ready=%b drop=%0d required 5/0/5",
                               fifo_level, in_ready, drop_count);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || fifo_level !== 4'd0 || in_ready !== 1'b1 ||
            drop_count !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset: got valid=%b level=%0d ready=%b drop=%0d required 0/0/1/0",
                     out_valid, fifo_level, in_ready, drop_count);
        end
        push_byte(8'h20);
        push_byte(8'h61);
        @(negedge clk);
        checks++;
        if (fifo_level !== 4'd1 || out_char !== 8'h61) begin
            errors++; $display("FAIL mid_after: got level=%0d char=%02h required 1/61",
                               fifo_level, out_char);
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_char   = 8'h00;
        out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_latency();
        test_fold_collapse();
        test_leading_sep();
        test_drops();
        test_full_backpressure();
        test_eos_pad_full();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
